// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and EX operand selector (RV32I core).
//
// Captures a decoded instruction over a valid/ready handshake and holds it
// under downstream stall. It drives the ALU operands a/b and the ALU select
// combinationally from the held fields. Optional MEM/WB forwarding and
// stall-time operand refresh are enabled with the macro ID_EX_FWD_EN. In
// the default build the forwarding ports are accepted but ignored.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             kill held instruction and any same-cycle capture
//   id_*              decode-side handshake and instruction fields
//   mem_fwd_*/wb_fwd_*  producer results for forwarding/refresh
//   ex_valid/ex_ready downstream handshake
//   alu_a/alu_b/alu_sel  ALU inputs
//   ex_store_data     forwarded rs2 value
//   ex_pc, ex_rd_addr, ex_reg_write, ex_illegal_op  held/qualified status
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [3:0]        id_alu_sel,
    input  logic              id_a_pc,
    input  logic              id_b_imm,
    input  logic              id_reg_write,
    input  logic              mem_fwd_we,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_fwd_we,
    input  logic [REG_AW-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [3:0]        alu_sel,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_illegal_op
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd_addr;
        logic [3:0]        alu_sel;
        logic              a_pc;
        logic              b_imm;
        logic              reg_write;
    } ex_payload_t;

    ex_payload_t     held;
    ex_payload_t     id_pl;
    logic            vld;
    logic            take;
    logic            stall;
    logic            wb_hit1, wb_hit2;
    logic [XLEN-1:0] rs1_val, rs2_val;

    assign id_pl = '{pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                     imm: id_imm, rs1_addr: id_rs1_addr, rs2_addr: id_rs2_addr,
                     rd_addr: id_rd_addr, alu_sel: id_alu_sel, a_pc: id_a_pc,
                     b_imm: id_b_imm, reg_write: id_reg_write};

    assign id_ready = !vld || ex_ready;
    assign take     = id_valid && id_ready;
    assign stall    = vld && !ex_ready;

`ifdef ID_EX_FWD_EN
    logic mem_hit1, mem_hit2;

    // x0 is hardwired zero, so a producer targeting it must never forward
    assign mem_hit1 = mem_fwd_we && (mem_fwd_rd == held.rs1_addr) && (held.rs1_addr != '0);
    assign mem_hit2 = mem_fwd_we && (mem_fwd_rd == held.rs2_addr) && (held.rs2_addr != '0);
    assign wb_hit1  = wb_fwd_we  && (wb_fwd_rd  == held.rs1_addr) && (held.rs1_addr != '0);
    assign wb_hit2  = wb_fwd_we  && (wb_fwd_rd  == held.rs2_addr) && (held.rs2_addr != '0);

    // MEM is the younger producer, so it wins over WB
    assign rs1_val = mem_hit1 ? mem_fwd_data : (wb_hit1 ? wb_fwd_data : held.rs1_data);
    assign rs2_val = mem_hit2 ? mem_fwd_data : (wb_hit2 ? wb_fwd_data : held.rs2_data);
`else
    // Hazard unit interlocks instead; forwarding inputs are intentionally unused
    logic unused_fwd;
    assign unused_fwd = ^{mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_we, wb_fwd_rd, wb_fwd_data};
    assign wb_hit1    = 1'b0;
    assign wb_hit2    = 1'b0;
    assign rs1_val    = held.rs1_data;
    assign rs2_val    = held.rs2_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld  <= 1'b0;
            held <= '0;
        end else begin
            if (flush)         vld <= 1'b0;
            else if (take)     vld <= 1'b1;
            else if (ex_ready) vld <= 1'b0;

            if (take && !flush) begin
                held <= id_pl;
            end else if (stall) begin
                // A WB producer retires while we wait; latch its value so the
                // operand stays correct once the forwarding source is gone.
                if (wb_hit1) held.rs1_data <= wb_fwd_data;
                if (wb_hit2) held.rs2_data <= wb_fwd_data;
            end
        end
    end

    assign ex_valid      = vld;
    assign alu_a         = held.a_pc  ? held.pc  : rs1_val;
    assign alu_b         = held.b_imm ? held.imm : rs2_val;
    assign alu_sel       = held.alu_sel;
    assign ex_store_data = rs2_val;
    assign ex_pc         = held.pc;
    assign ex_rd_addr    = held.rd_addr;
    assign ex_reg_write  = vld && held.reg_write;
    assign ex_illegal_op = vld && (held.alu_sel > 4'd9);

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register and EX-stage operand selector of the pipelined RV32I core. Captures decoded instructions from decode over a valid/ready handshake and holds them under stall. Applies MEM- and WB-stage forwarding and drives operands plus the ALU select straight into the ALU (a, b, ALU_Sel inputs). Also keeps held operands coherent while stalled, so forwarded values are not lost when producers retire.

Parameters:
XLEN, 32, datapath width (a, b and all data ports)
REG_AW, 5, register-address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
flush  in  1  kill the held instruction (branch mispredict/trap)
id_valid  in  1  decode presents an instruction
id_ready  out  1  stage can accept this cycle
id_pc  in  XLEN  instruction PC
id_rs1_data  in  XLEN  regfile read of rs1
id_rs2_data  in  XLEN  regfile read of rs2
id_imm  in  XLEN  sign-extended immediate
id_rs1_addr  in  REG_AW  rs1 index
id_rs2_addr  in  REG_AW  rs2 index
id_rd_addr  in  REG_AW  destination index
id_alu_sel  in  4  ALU operation code, 0..9 legal
id_a_pc  in  1  operand A = PC (AUIPC/JAL)
id_b_imm  in  1  operand B = immediate
id_reg_write  in  1  instruction writes rd
mem_fwd_we  in  1  MEM-stage result valid and writing
mem_fwd_rd  in  REG_AW  MEM-stage rd
mem_fwd_data  in  XLEN  MEM-stage result
wb_fwd_we  in  1  WB-stage write enable
wb_fwd_rd  in  REG_AW  WB-stage rd
wb_fwd_data  in  XLEN  WB-stage write data
ex_valid  out  1  held instruction valid
ex_ready  in  1  downstream (EX/MEM) accepts this cycle
alu_a  out  XLEN  ALU operand a
alu_b  out  XLEN  ALU operand b
alu_sel  out  4  ALU operation select
ex_store_data  out  XLEN  forwarded rs2 value (store data)
ex_pc  out  XLEN  held PC
ex_rd_addr  out  REG_AW  held rd
ex_reg_write  out  1  held reg_write AND ex_valid
ex_illegal_op  out  1  ex_valid AND held alu_sel > 9

Behaviour:
- Reset (rst_n=0 at edge): ex_valid=0. All held payload = 0, so alu_sel=0 and alu_a=alu_b=0 when no forwarding applies. ex_reg_write=0, ex_illegal_op=0. Reset overrides flush and capture.
- id_ready = !ex_valid || ex_ready (combinational; no bubble on back-to-back transfer).
- Capture: id_valid && id_ready latches all id_* fields next edge and sets ex_valid=1.
- Retire without refill (ex_valid && ex_ready && !id_valid): ex_valid=0.
- Flush: next edge ex_valid=0 regardless of id_valid/ex_ready. Same-cycle id transfer is discarded. Payload may keep its old values but outputs are qualified by ex_valid.
- Stall (ex_valid && !ex_ready): all held fields unchanged except the operand refresh below.
- Forwarding, combinational from held rs addresses:
  - rsN_val = mem_fwd_data if mem_fwd_we && mem_fwd_rd==rsN && rsN!=0.
  - Else wb_fwd_data if wb_fwd_we && wb_fwd_rd==rsN && rsN!=0.
  - Else the held regfile value.
  - MEM has priority over WB. Register x0 is never forwarded.
- Refresh while stalled: each edge, for each held operand with a matching wb_fwd (same rules, rsN!=0), overwrite the stored regfile value with wb_fwd_data. Values retiring from WB therefore persist.
- alu_a = id_a_pc ? held pc : rs1_val. alu_b = id_b_imm ? held imm : rs2_val. ex_store_data = rs2_val always.
- Latency: decode to ALU inputs is 1 cycle. Forwarding is same-cycle (0 added latency).
- ex_illegal_op: alu_sel is passed through unchanged and the flag is raised; the stage does not trap.

Optional Feature:
ID_EX_FWD_EN
- Defined: forwarding muxes and stall refresh as above.
- Undefined: rsN_val = held regfile value. No refresh. mem_fwd_*/wb_fwd_* ports remain but are ignored. The hazard unit must interlock instead.

Test Plan:
- Reset: rst_n=0 two cycles with id_valid=1 -> ex_valid=0, alu_sel=0, alu_a=alu_b=0, id_ready=1.
- Basic capture: id rs1_data=5, rs2_data=7, alu_sel=1, ex_ready=1 -> next cycle ex_valid=1, alu_a=5, alu_b=7, alu_sel=1. Back-to-back stream of 4 instructions has no gaps.
- Forward priority: held rs1=3, mem_fwd(we=1,rd=3,data=0xAA), wb_fwd(we=1,rd=3,data=0xBB) -> alu_a=0xAA. rs1=0 with mem_fwd rd=0 -> alu_a = held value.
- Stall refresh: hold ex_ready=0 for 3 cycles. wb_fwd(rd=2,data=0x1234) in cycle 1 only, rs2=2 -> alu_b=0x1234 in cycles 1-3, and after release.
- Flush collision: ex_valid=1, id_valid=1, ex_ready=1, flush=1 -> next cycle ex_valid=0, ex_reg_write=0.
- Immediate/PC/illegal: id_a_pc=1, id_b_imm=1, pc=0x100, imm=0xFFFFFFFC, alu_sel=12 -> alu_a=0x100, alu_b=0xFFFFFFFC, ex_illegal_op=1.
